// File: rtl/match_pkg.sv
`default_nettype none
// ============================================================================
// Module  : match_pkg
// Brief   : FSM state type, derived-width helpers and popcount for match_arbiter
// Rev     : 1.0
// ============================================================================
package match_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Upper bound on the operand width that popcount accepts.
    localparam int MAX_WIDTH = 256;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [8:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + {8'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_bits.sv
`default_nettype none
// ============================================================================
// Module  : match_bits
// Brief   : Combinational bitwise equality (XNOR) of two operand words
// Rev     : 1.0
// ============================================================================
module match_bits #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] match
);

    assign match = ~(a ^ b);

endmodule
`default_nettype wire

// File: rtl/match_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : match_arbiter
// Brief   : Round-robin scheduler sharing one match_bits comparator among
//           N_REQ requesters; one transaction every three cycles at most.
// Rev     : 1.0
// ============================================================================
module match_arbiter
    import match_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = id_width(N_REQ),
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_flat,
    input  logic [N_REQ*WIDTH-1:0] b_flat,
    output logic [N_REQ-1:0]       ack,
    output logic                   result_valid,
    output logic [ID_W-1:0]        result_id,
    output logic [WIDTH-1:0]       match_out,
    output logic [CNT_W-1:0]       match_cnt,
    output logic                   all_match,
    output logic                   busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_result_id;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_match;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_all;

    logic              w_any;
    logic              w_found;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_winner;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;
    logic [WIDTH-1:0]  w_match;
    logic [CNT_W-1:0]  w_cnt;
    logic [ID_W-1:0]   w_ptr_nxt;

    assign w_any = |req;

    // Priority search starting at ptr and wrapping: the request vector seen
    // rotated so that ptr is the highest-priority position.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = ID_W'((int'(r_ptr) + i) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_a = a_flat[i*WIDTH +: WIDTH];
                w_sel_b = b_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    match_bits #(
        .WIDTH (WIDTH)
    ) u_match_bits (
        .a     (r_a),
        .b     (r_b),
        .match (w_match)
    );

    assign w_cnt     = CNT_W'(popcount(MAX_WIDTH'(w_match)));
    assign w_ptr_nxt = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = CMP;
            CMP:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_result_id <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_match     <= '0;
            r_cnt       <= '0;
            r_all       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        r_id <= w_winner;
                    end
                end
                CMP: begin
                    r_match     <= w_match;
                    r_cnt       <= w_cnt;
                    r_all       <= &w_match;
                    r_result_id <= r_id;
                end
                DONE: begin
                    r_ptr <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (r_state == DONE) begin
            for (int i = 0; i < N_REQ; i++) begin
                ack[i] = (r_id == ID_W'(i));
            end
        end
    end

    assign result_valid = (r_state == DONE);
    assign result_id    = r_result_id;
    assign match_out    = r_match;
    assign match_cnt    = r_cnt;
    assign all_match    = r_all;
    assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_match_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_match_arbiter
// Brief   : Directed scoreboard bench for match_arbiter (N_REQ=4, WIDTH=8)
// Rev     : 1.0
// ============================================================================
module tb_match_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0] ack;
    logic         result_valid;
    logic [1:0]   result_id;
    logic [W-1:0] match_out;
    logic [3:0]   match_cnt;
    logic         all_match;
    logic         busy;

    match_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .a_flat       (a_flat),
        .b_flat       (b_flat),
        .ack          (ack),
        .result_valid (result_valid),
        .result_id    (result_id),
        .match_out    (match_out),
        .match_cnt    (match_cnt),
        .all_match    (all_match),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] m;
        logic [3:0] c;
        logic       all;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [N-1:0] mon_ack;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] m, input logic [3:0] c, input logic all);
        exp_t e;
        e.id  = id;
        e.m   = m;
        e.c   = c;
        e.all = all;
        q.push_back(e);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        a_flat[i*W +: W] = a;
        b_flat[i*W +: W] = b;
    endtask

    // Returns the number of falling edges waited before result_valid.
    task automatic wait_valid(input string name, output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual=no result required=result within 20 cycles", name);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (result_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: actual id=%0d required=no result", result_id);
                end else begin
                    mon_e   = q.pop_front();
                    mon_ack = 4'b0001 << mon_e.id;
                    check("result_id", 32'(result_id), 32'(mon_e.id));
                    check("ack",       32'(ack),       32'(mon_ack));
                    check("match_out", 32'(match_out), 32'(mon_e.m));
                    check("match_cnt", 32'(match_cnt), 32'(mon_e.c));
                    check("all_match", 32'(all_match), 32'(mon_e.all));
                end
            end else if (ack != '0) begin
                checks++;
                errors++;
                $display("FAIL stray_ack: actual=%0h required=0", ack);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        req    = 4'($urandom);
        a_flat = $urandom;
        b_flat = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",       32'(ack), 0);
        check("rst_valid",     32'(result_valid), 0);
        check("rst_id",        32'(result_id), 0);
        check("rst_match",     32'(match_out), 0);
        check("rst_cnt",       32'(match_cnt), 0);
        check("rst_all",       32'(all_match), 0);
        check("rst_busy",      32'(busy), 0);
        req   = '0;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 0);

        // Single request, equal operands
        a_flat = '0;
        b_flat = '0;
        set_ops(0, 8'hA5, 8'hA5);
        push(2'd0, 8'hFF, 4'd8, 1'b1);
        req = 4'b0001;
        wait_valid("t2", n);
        check("t2_latency", n, 2);
        req = '0;
        @(posedge clk); #1;

        // Mixed operands on requester 2
        set_ops(2, 8'h3C, 8'h35);
        push(2'd2, 8'hF6, 4'd6, 1'b0);
        req = 4'b0100;
        wait_valid("t3", n);
        check("t3_latency", n, 2);
        req = '0;
        @(posedge clk); #1;

        // Full contention from ptr=0; requester 0 operands change after latch
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_ops(0, 8'h12, 8'h34);
        set_ops(1, 8'hFF, 8'h00);
        set_ops(2, 8'h5A, 8'h5A);
        set_ops(3, 8'hC3, 8'hC2);
        push(2'd0, 8'hD9, 4'd5, 1'b0);
        push(2'd1, 8'h00, 4'd0, 1'b0);
        push(2'd2, 8'hFF, 4'd8, 1'b1);
        push(2'd3, 8'hFE, 4'd7, 1'b0);
        push(2'd0, 8'hFF, 4'd8, 1'b1);
        req = 4'b1111;
        @(posedge clk); #1;
        set_ops(0, 8'h12, 8'h12);
        for (int k = 0; k < 5; k++) begin
            wait_valid("t4", n);
            if (k == 0) check("t4_first_latency", n, 1);
            else        check("t4_spacing", n, 2);
        end
        req = '0;
        @(posedge clk); #1;

        // Wrap-around: serve 1, then 3 before 0
        set_ops(1, 8'hAA, 8'h55);
        push(2'd1, 8'h00, 4'd0, 1'b0);
        req = 4'b0010;
        wait_valid("t5_id1", n);
        req = '0;
        @(posedge clk); #1;
        push(2'd3, 8'hFE, 4'd7, 1'b0);
        push(2'd0, 8'hFF, 4'd8, 1'b1);
        req = 4'b1001;
        wait_valid("t5_id3", n);
        req = 4'b0001;
        wait_valid("t5_id0", n);
        check("t5_id0_spacing", n, 2);
        req = '0;
        @(posedge clk); #1;
        set_ops(2, 8'hF0, 8'h0F);
        push(2'd2, 8'h00, 4'd0, 1'b0);
        req = 4'b0100;
        wait_valid("t5_id2", n);
        req = '0;
        @(posedge clk); #1;

        // Reset during CMP aborts the transaction and clears ptr
        req = 4'b0010;
        @(posedge clk); #1;
        check("t6_busy_cmp", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  32'(busy), 0);
        check("t6_rst_valid", 32'(result_valid), 0);
        check("t6_rst_ack",   32'(ack), 0);
        check("t6_rst_id",    32'(result_id), 0);
        req = 4'b0011;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(2'd0, 8'hFF, 4'd8, 1'b1);
        push(2'd1, 8'h00, 4'd0, 1'b0);
        wait_valid("t6_id0", n);
        check("t6_latency", n, 2);
        req = 4'b0010;
        wait_valid("t6_id1", n);
        req = '0;
        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_arbiter.md
Name: match_arbiter

Overview:
Shares one combinational match_bits comparator (bitwise XNOR of two operand words) between N_REQ requesters. It uses round-robin arbitration and a 3-state FSM. Per request it latches the operands, registers the match vector, and adds a popcount and an all-match flag. It returns a one-cycle ack to the winning requester. It sits between the operand sources and the shared comparator as the resource scheduler.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- WIDTH, 8, operand and match width in bits (≥1).
- ID_W, $clog2(N_REQ), width of the requester index (derived; not overridable).
- CNT_W, $clog2(WIDTH+1), width of the popcount (derived; not overridable).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  N_REQ  per-requester request, level; held until ack.
- a_flat  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_flat  in  N_REQ*WIDTH  operand B, same packing as a_flat.
- ack  out  N_REQ  one-hot, one-cycle pulse to the requester whose result is valid.
- result_valid  out  1  one-cycle pulse, coincident with ack.
- result_id  out  ID_W  index of the served requester.
- match_out  out  WIDTH  registered ~(a ^ b) of the served operands.
- match_cnt  out  CNT_W  number of ones in match_out (0..WIDTH).
- all_match  out  1  1 when match_out is all ones.
- busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ptr=0.
  - ack, result_valid, result_id, match_out, match_cnt, all_match and busy all 0.
  - The latched operands are cleared to 0.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - If req is nonzero, choose the winner: the first set bit searching ptr, ptr+1, … N_REQ-1, 0, … ptr-1 (wrap-around).
  - Latch that requester's a and b slices and its id; go to CMP.
  - If req is 0, stay in IDLE.
- CMP:
  - The shared match_bits instance sees the latched operands.
  - At the end of the cycle, register match_out, match_cnt (popcount of the XNOR result, zero-extended) and all_match.
  - Go to DONE.
- DONE:
  - result_valid=1, ack[id]=1, result_id=id for exactly this cycle.
  - ptr ← (id+1) mod N_REQ; go to IDLE.
- Timing: a request accepted in IDLE at cycle T acks at T+2. The next grant is possible at T+3, so peak throughput is one transaction per 3 cycles.
- Output hold: match_out, match_cnt, all_match and result_id hold their values until the next CMP/DONE overwrites them. Only ack and result_valid are pulses.
- Requester protocol:
  - A requester drops req in the cycle after its ack.
  - If req is still high in IDLE at T+3, it counts as a new request, arbitrated with ptr already advanced.
- Operand changes: changes on a_flat/b_flat after the latch (T) have no effect on the current transaction.
- req withdrawn early (in CMP or DONE): the transaction still completes and the ack is still issued.
- Simultaneous requests: only one grant per IDLE visit. Losers keep waiting; none is ever dropped.
- Fairness: with all N_REQ requests held, each requester is served once every 3*N_REQ cycles.
- Reset mid-operation (CMP or DONE): the transaction is aborted, no ack is issued, and ptr returns to 0.

Decomposition:
- Shared package match_pkg holds:
  - the state typedef (IDLE, CMP, DONE);
  - the function clog2-based widths ID_W and CNT_W;
  - a popcount function over WIDTH.
- One sub-module: the existing combinational match_bits, parameterised to WIDTH, instantiated once as the shared resource.
- Round-robin selection is inline logic (a priority search over the request vector rotated by ptr); it gets no separate module.

Test Plan:
1. Reset: rst_n=0 with random req/operands → every output is 0 and busy=0. After release with req=0, the block stays IDLE and ack is never asserted.
2. Single request, equal operands: req=4'b0001, a0=8'hA5, b0=8'hA5 → at T+2, ack=4'b0001, result_valid=1, result_id=0, match_out=8'hFF, match_cnt=8, all_match=1.
3. Single request, mixed operands on requester 2: a2=8'h3C, b2=8'h35 → match_out=8'hF6, match_cnt=6, all_match=0, result_id=2.
4. Full contention: req=4'b1111 held, operands different per requester → acks to ids 0,1,2,3,0 spaced 3 cycles apart. Each match_out equals the XNOR of that requester's operands; operands changed after the latch do not alter results.
5. Wrap-around priority: serve id 1 (ptr becomes 2), then raise req=4'b1001 → id 3 is served before id 0. Then with a2=8'hF0, b2=8'h0F alone → match_out=8'h00, match_cnt=0.
6. Reset mid-operation: assert rst_n=0 during CMP for requester 1 → no ack appears; after release with req=4'b0011, id 0 is served first (ptr back to 0).
